// File: rtl/uart_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : uart_pkg                                                   |
// | Purpose  : Shared types and constants for the UART transmit path.     |
// |            tx_state_e encodes the serialiser FSM; PARITY is always    |
// |            encoded so both builds share one state map, but it is only |
// |            visited when UART_TX_PARITY_EN is defined.                 |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
package uart_pkg;

  localparam int   UART_DATA_BITS    = 8;
  localparam logic UART_IDLE_LEVEL   = 1'b1;
  localparam int   UART_CLKS_PER_BIT = 217;  // 25 MHz / 115200 baud

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : uart_tx_fifo                                               |
// | Purpose  : FIFO_DEPTH x WIDTH synchronous FIFO holding bytes awaiting |
// |            transmission. Status flags come from the registered count  |
// |            only, so there is no combinational path from wr_en_i.      |
// | Ports    : clk_i, rst_ni      clock, async active-low reset           |
// |            wr_en_i/wr_data_i  push request and data                   |
// |            rd_en_i/rd_data_o  pop request, head-of-queue data         |
// |            full_o, empty_o    occupancy flags                         |
// |            overflow_o         one-cycle pulse when a push is dropped  |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int WIDTH      = UART_DATA_BITS
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             overflow_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] C_COUNT_FULL = (AW+1)'(FIFO_DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [WIDTH-1:0] mem_d [FIFO_DEPTH];

  logic w_wr_accept;
  logic w_rd_accept;

  assign full_o      = (count_q == C_COUNT_FULL);
  assign empty_o     = (count_q == '0);
  assign overflow_o  = overflow_q;
  assign rd_data_o   = mem_q[rd_ptr_q];

  // Acceptance is judged on the pre-edge count: a full FIFO refuses a
  // write even if the same cycle pops an entry.
  assign w_wr_accept = wr_en_i && !full_o;
  assign w_rd_accept = rd_en_i && !empty_o;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = wr_en_i && full_o;
    mem_d      = mem_q;

    if (w_wr_accept) begin
      mem_d[wr_ptr_q] = wr_data_i;
      wr_ptr_d        = wr_ptr_q + AW'(1);  // power-of-2 depth wraps naturally
    end
    if (w_rd_accept) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    case ({w_wr_accept, w_rd_accept})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage carries no reset; validity is tracked by the pointers/count.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule : uart_tx_fifo
`default_nettype wire

// File: rtl/uart_tx_buffered.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : uart_tx_buffered                                           |
// | Purpose  : Buffered UART transmitter. Bytes are queued in a small     |
// |            FIFO and serialised LSB first as 8N1 frames. Defining      |
// |            UART_TX_PARITY_EN inserts an even-parity bit (8E1).        |
// | Ports    : clk_i, rst_ni      clock, async active-low reset           |
// |            wr_en_i, tx_byte_i byte push into the FIFO                 |
// |            full_o, empty_o    FIFO status                             |
// |            overflow_o         pulse when a push is dropped            |
// |            tx_serial_o        serial line, idle high, from a flop     |
// |            tx_active_o        high while a frame is on the line       |
// |            tx_done_o          pulse on the last stop-bit cycle        |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       wr_en_i,
  input  logic [7:0] tx_byte_i,
  output logic       full_o,
  output logic       empty_o,
  output logic       overflow_o,
  output logic       tx_serial_o,
  output logic       tx_active_o,
  output logic       tx_done_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] C_CNT_MAX = CW'(CLKS_PER_BIT - 1);

  tx_state_e                  state_q, state_d;
  logic [CW-1:0]              clk_cnt_q, clk_cnt_d;
  logic [2:0]                 bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0]  shift_q, shift_d;
  logic                       tx_serial_q, tx_serial_d;
  logic                       tx_active_q, tx_active_d;
  logic                       tx_done_q, tx_done_d;

  logic                       fifo_rd_en;
  logic                       fifo_empty;
  logic [UART_DATA_BITS-1:0]  fifo_rd_data;
  logic                       bit_end;

  uart_tx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (UART_DATA_BITS)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .wr_en_i    (wr_en_i),
    .wr_data_i  (tx_byte_i),
    .rd_en_i    (fifo_rd_en),
    .rd_data_o  (fifo_rd_data),
    .full_o     (full_o),
    .empty_o    (fifo_empty),
    .overflow_o (overflow_o)
  );

  assign empty_o     = fifo_empty;
  assign tx_serial_o = tx_serial_q;
  assign tx_active_o = tx_active_q;
  assign tx_done_o   = tx_done_q;
  assign bit_end     = (clk_cnt_q == C_CNT_MAX);

  // Next-state logic. The FSM state leads the line by one cycle: the
  // serial/active flops are loaded from the current state, which gives
  // the write-to-start-bit latency of two edges.
  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = bit_end ? '0 : clk_cnt_q + CW'(1);
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    fifo_rd_en = 1'b0;
    tx_done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          shift_d    = fifo_rd_data;
          bit_idx_d  = '0;
          state_d    = START;
        end
      end
      START: begin
        if (bit_end) begin
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          tx_done_d = 1'b1;
          // Chain straight into the next frame so queued bytes leave
          // with no idle gap on the line.
          if (!fifo_empty) begin
            fifo_rd_en = 1'b1;
            shift_d    = fifo_rd_data;
            bit_idx_d  = '0;
            state_d    = START;
          end else begin
            state_d    = IDLE;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        clk_cnt_d = '0;
      end
    endcase
  end

  // Line level and activity flag derived from the current state.
  always_comb begin
    tx_serial_d = UART_IDLE_LEVEL;
    tx_active_d = (state_q != IDLE);
    case (state_q)
      START:   tx_serial_d = 1'b0;
      DATA:    tx_serial_d = shift_q[bit_idx_q];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_serial_d = ^shift_q;
`endif
      default: tx_serial_d = UART_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      clk_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      tx_serial_q <= UART_IDLE_LEVEL;
      tx_active_q <= 1'b0;
      tx_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      tx_serial_q <= tx_serial_d;
      tx_active_q <= tx_active_d;
      tx_done_q   <= tx_done_d;
    end
  end

endmodule : uart_tx_buffered
`default_nettype wire

// File: tb/tb_uart_tx_buffered.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : tb_uart_tx_buffered                                        |
// | Purpose  : Self-checking bench for uart_tx_buffered. A line monitor   |
// |            decodes frames and compares them with a scoreboard queue   |
// |            filled when bytes are written. Honours UART_TX_PARITY_EN.  |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module tb_uart_tx_buffered;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic       clk_i     = 1'b0;
  logic       rst_ni    = 1'b0;
  logic       wr_en_i   = 1'b0;
  logic [7:0] tx_byte_i = 8'h00;
  logic       full_o, empty_o, overflow_o;
  logic       tx_serial_o, tx_active_o, tx_done_o;

  uart_tx_buffered #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .wr_en_i     (wr_en_i),
    .tx_byte_i   (tx_byte_i),
    .full_o      (full_o),
    .empty_o     (empty_o),
    .overflow_o  (overflow_o),
    .tx_serial_o (tx_serial_o),
    .tx_active_o (tx_active_o),
    .tx_done_o   (tx_done_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;
  int edge_cnt = 0;
  logic [7:0] exp_q[$];

  always @(posedge clk_i) edge_cnt++;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- line monitor / scoreboard consumer ----------------
  int         mon_cyc = -1;
  int         bidx;
  logic [7:0] mon_byte = 8'h00;
  logic [7:0] exp_b;
  int         frames_seen = 0;
  int         start_edges[$];

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      mon_cyc = -1;
    end else begin
      if (mon_cyc < 0 && tx_serial_o == 1'b0) begin
        mon_cyc = 0;
        start_edges.push_back(edge_cnt);
      end
      if (mon_cyc >= 0) begin
        check_val("active_in_frame", 32'(tx_active_o), 32'd1);
        check_val("done_position", 32'(tx_done_o), 32'(mon_cyc == FRAME - 1));
        if (mon_cyc % CPB == CPB / 2) begin
          bidx = mon_cyc / CPB;
          if (bidx == 0)
            check_val("start_bit", 32'(tx_serial_o), 32'd0);
          else if (bidx <= 8)
            mon_byte[bidx-1] = tx_serial_o;
`ifdef UART_TX_PARITY_EN
          else if (bidx == 9)
            check_val("parity_bit", 32'(tx_serial_o), 32'(^mon_byte));
`endif
          else
            check_val("stop_bit", 32'(tx_serial_o), 32'd1);
        end
        if (mon_cyc == FRAME - 1) begin
          frames_seen++;
          check_val("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            exp_b = exp_q.pop_front();
            check_val("frame_byte", 32'(mon_byte), 32'(exp_b));
          end
          mon_cyc = -1;
        end else begin
          mon_cyc++;
        end
      end else begin
        check_val("idle_active", 32'(tx_active_o), 32'd0);
        check_val("idle_done", 32'(tx_done_o), 32'd0);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_byte(input logic [7:0] b, input bit accept, output int edge_n);
    @(negedge clk_i);
    wr_en_i   = 1'b1;
    tx_byte_i = b;
    if (accept) exp_q.push_back(b);
    @(posedge clk_i);
    #1;
    edge_n    = edge_cnt;
    wr_en_i   = 1'b0;
    tx_byte_i = 8'($urandom);  // later changes must not affect queued data
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    int quiet = 0;
    while (quiet < 3 && n < max_cyc) begin
      @(posedge clk_i);
      #1;
      n++;
      if (empty_o && !tx_active_o && mon_cyc < 0) quiet++;
      else quiet = 0;
    end
    check_val("idle_timeout", 32'(n < max_cyc), 32'd1);
  endtask

  task automatic single_byte(input logic [7:0] b);
    int n0, n, fall_e, done_e, f0;
    f0 = frames_seen;
    push_byte(b, 1'b1, n0);
    n = 0;
    while (tx_serial_o !== 1'b0 && n < 20) begin
      @(posedge clk_i); #1; n++;
    end
    fall_e = edge_cnt;
    check_val("start_latency", 32'(fall_e - n0), 32'd2);
    n = 0;
    while (tx_done_o !== 1'b1 && n < 3 * FRAME) begin
      @(posedge clk_i); #1; n++;
    end
    done_e = edge_cnt;
    check_val("done_latency", 32'(done_e - n0), 32'(FRAME + 1));
    wait_idle(4 * FRAME);
    check_val("single_frames", 32'(frames_seen - f0), 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int e, f0, s0;
    int n;

    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    check_val("rst_serial", 32'(tx_serial_o), 32'd1);
    check_val("rst_active", 32'(tx_active_o), 32'd0);
    check_val("rst_done", 32'(tx_done_o), 32'd0);
    check_val("rst_overflow", 32'(overflow_o), 32'd0);
    check_val("rst_full", 32'(full_o), 32'd0);
    check_val("rst_empty", 32'(empty_o), 32'd1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (2) @(posedge clk_i);

    // Single frames
    single_byte(8'hAB);
    single_byte(8'h07);

    // Back-to-back frames
    f0 = frames_seen;
    s0 = start_edges.size();
    push_byte(8'h00, 1'b1, e);
    push_byte(8'hFF, 1'b1, e);
    push_byte(8'h55, 1'b1, e);
    wait_idle(6 * FRAME);
    check_val("b2b_frames", 32'(frames_seen - f0), 32'd3);
    check_val("b2b_starts", 32'(start_edges.size() - s0), 32'd3);
    if (start_edges.size() - s0 == 3) begin
      check_val("b2b_gap1", 32'(start_edges[s0+1] - start_edges[s0]), 32'(FRAME));
      check_val("b2b_gap2", 32'(start_edges[s0+2] - start_edges[s0+1]), 32'(FRAME));
    end
    check_val("b2b_empty", 32'(empty_o), 32'd1);

    // Overflow: six consecutive writes, the sixth is dropped
    f0 = frames_seen;
    for (int i = 0; i < 6; i++) begin
      push_byte(8'h10 + 8'(i * 17), i < 5, e);
      check_val("ovf_pulse", 32'(overflow_o), 32'(i == 5));
      if (i == 4) check_val("ovf_full", 32'(full_o), 32'd1);
    end
    @(posedge clk_i); #1;
    check_val("ovf_clear", 32'(overflow_o), 32'd0);
    wait_idle(8 * FRAME);
    check_val("ovf_frames", 32'(frames_seen - f0), 32'd5);

    // Reset during DATA bit 3 with two bytes queued
    push_byte(8'hC3, 1'b1, e);
    push_byte(8'h5A, 1'b1, e);
    push_byte(8'h96, 1'b1, e);
    n = 0;
    while (mon_cyc != 4 * CPB + 1 && n < 4 * FRAME) begin
      @(negedge clk_i); n++;
    end
    check_val("reach_data_bit3", 32'(n < 4 * FRAME), 32'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    check_val("midrst_serial", 32'(tx_serial_o), 32'd1);
    check_val("midrst_empty", 32'(empty_o), 32'd1);
    check_val("midrst_active", 32'(tx_active_o), 32'd0);
    exp_q.delete();
    s0 = start_edges.size();
    f0 = frames_seen;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (3 * FRAME) @(posedge clk_i);
    #1;
    check_val("post_rst_starts", 32'(start_edges.size() - s0), 32'd0);
    check_val("post_rst_frames", 32'(frames_seen - f0), 32'd0);
    check_val("post_rst_serial", 32'(tx_serial_o), 32'd1);
    check_val("post_rst_empty", 32'(empty_o), 32'd1);

    // The block still works after the mid-frame reset
    single_byte(8'h3C);
    check_val("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_uart_tx_buffered
`default_nettype wire
